// File: rtl/vga_pixel_feeder_if.sv
// Frame-buffer read port: request/acknowledge address phase plus in-order
// response beats. The feeder is the master, the memory is the slave.
interface vga_pixel_feeder_if #(
  parameter int ADDR_W = 19
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_valid;
  logic [23:0]       mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_valid,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_valid,
    output mem_data
  );
endinterface

// File: rtl/vga_pixel_feeder.sv
// Prefetching raster-order pixel source for the VGA controller.
// Define VGA_PIXEL_FEEDER_TESTPAT_EN to replace memory data with colour bars.
module vga_pixel_feeder #(
  parameter int          H_ACTIVE        = 640,
  parameter int          V_ACTIVE        = 480,
  parameter int          ADDR_W          = 19,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic               i_request,
  output logic [23:0]        o_color,
  vga_pixel_feeder_if.master mem,
  output logic               o_underflow,
  output logic [15:0]        o_underflow_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_r;
  logic [23:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  outst_r;
  logic [ADDR_W-1:0] addr_r;
  logic              req_r;
  logic [23:0]       color_r;
  logic              underflow_r;
  logic [15:0]       ucnt_r;

  logic              ack_fire_s;
  logic              rsp_s;
  logic              push_s;
  logic [23:0]       push_data_s;
  logic              serve_s;
  logic              pop_s;
  logic              starve_s;
  logic              run_next_s;
  logic              credit_s;
  logic              req_next_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [CNT_W-1:0]  outst_next_s;

`ifdef VGA_PIXEL_FEEDER_TESTPAT_EN
  localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);

  logic [X_W-1:0] x_r;

  // Bar index bits map directly onto inverted channel enables (white..black)
  function automatic logic [23:0] bar_color(input logic [X_W-1:0] x);
    logic [2:0] bar;
    bar = 3'(int'(x) / BAR_W);
    return {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  endfunction

  // Generator source: one entry per cycle whenever the FIFO has room
  always_comb begin
    ack_fire_s  = 1'b0;
    rsp_s       = 1'b0;
    push_s      = (state_r == RUN) & ~i_frame_start & (count_r < DEPTH_C);
    push_data_s = bar_color(x_r);
  end

  // Horizontal position of the next generated pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_r <= {X_W{1'b0}};
    end else if (i_frame_start) begin
      x_r <= {X_W{1'b0}};
    end else if (push_s) begin
      x_r <= (x_r == X_LAST) ? {X_W{1'b0}} : x_r + X_W'(1);
    end
  end
`else
  // Memory source: responses with no matching request are ignored
  always_comb begin
    ack_fire_s  = req_r & mem.mem_ack;
    rsp_s       = mem.mem_valid & (outst_r != CNT_ZERO);
    push_s      = (state_r == RUN) & rsp_s & ~i_frame_start;
    push_data_s = mem.mem_data;
  end
`endif

  // Serve decision, occupancy/credit bookkeeping and next fetch request
  always_comb begin
    serve_s  = (state_r == RUN) & i_request & ~i_frame_start;
    pop_s    = serve_s & (count_r != CNT_ZERO);
    starve_s = serve_s & (count_r == CNT_ZERO);

    if (i_frame_start) begin
      count_next_s = CNT_ZERO;
    end else if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end

    if (ack_fire_s && !rsp_s) begin
      outst_next_s = outst_r + CNT_ONE;
    end else if (rsp_s && !ack_fire_s) begin
      outst_next_s = outst_r - CNT_ONE;
    end else begin
      outst_next_s = outst_r;
    end

    // A frame start always drops the request for one cycle
    run_next_s = ~i_frame_start &
                 ((state_r == RUN) | ((state_r == FLUSH) & (outst_r == CNT_ZERO)));
    credit_s   = ({1'b0, count_next_s} + {1'b0, outst_next_s}) < {1'b0, DEPTH_C};
`ifdef VGA_PIXEL_FEEDER_TESTPAT_EN
    req_next_s = 1'b0;
`else
    req_next_s = run_next_s & credit_s;
`endif
  end

  // FIFO storage
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // State machine, FIFO pointers, fetch port and serve outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      rd_ptr_r    <= PTR_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      outst_r     <= CNT_ZERO;
      addr_r      <= ADDR_ZERO;
      req_r       <= 1'b0;
      color_r     <= 24'h000000;
      underflow_r <= 1'b0;
      ucnt_r      <= 16'h0000;
    end else begin
      count_r     <= count_next_s;
      outst_r     <= outst_next_s;
      req_r       <= req_next_s;
      underflow_r <= starve_s;
      if (starve_s && (ucnt_r != 16'hFFFF)) begin
        ucnt_r <= ucnt_r + 16'd1;
      end
      if (i_request) begin
        color_r <= pop_s ? fifo_mem_r[rd_ptr_r] : UNDERFLOW_COLOR;
      end
      if (i_frame_start) begin
        rd_ptr_r <= PTR_ZERO;
        wr_ptr_r <= PTR_ZERO;
        addr_r   <= ADDR_ZERO;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        if (ack_fire_s) begin
          addr_r <= (addr_r == LAST_ADDR) ? ADDR_ZERO : addr_r + ADDR_ONE;
        end
      end
      // An ack coinciding with the frame start is still owed a response
      case (state_r)
        IDLE: begin
          if (i_frame_start) begin
            state_r <= RUN;
          end
        end
        RUN, FLUSH: begin
          if (i_frame_start) begin
            state_r <= ((outst_r != CNT_ZERO) || ack_fire_s) ? FLUSH : RUN;
          end else if ((state_r == FLUSH) && (outst_r == CNT_ZERO)) begin
            state_r <= RUN;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign mem.mem_req     = req_r;
  assign mem.mem_addr    = addr_r;
  assign o_color         = color_r;
  assign o_underflow     = underflow_r;
  assign o_underflow_cnt = ucnt_r;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Bench for vga_pixel_feeder: directed table, corner sequences and random
// traffic checked against a queue-based model of the serving rules.
module tb_vga_pixel_feeder;

  localparam int          H   = 32;
  localparam int          V   = 4;
  localparam int          AW  = 8;
  localparam int          D   = 16;
  localparam int          PIX = H * V;
  localparam logic [23:0] UFC = 24'hA5A5A5;
  localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        fs    = 1'b0;
  logic        rq    = 1'b0;
  logic [23:0] color;
  logic        uf;
  logic [15:0] ucnt;

  vga_pixel_feeder_if #(.ADDR_W(AW)) mem_if ();

  vga_pixel_feeder #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(D), .UNDERFLOW_COLOR(UFC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_request(rq),
    .o_color(color), .mem(mem_if), .o_underflow(uf), .o_underflow_cnt(ucnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct { int due; logic [23:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  int          cyc = 0;
  int          lat = 2;
  int          last_due = -1;

  logic [23:0] q[$];
  int          m_state = S_IDLE;
  int          m_out = 0;
  int          m_addr = 0;
  int          m_ucnt = 0;
  logic [23:0] exp_color = 24'h000000;
  logic        exp_uf = 1'b0;
  logic        prev_hold = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic        last_fire = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance memory and reference model, check outputs
  task automatic cycle(input logic f, input logic r, input logic a);
    logic fire, valid, rsp;
    logic [23:0] data;
    rsp_t e;
    int d;
    fs = f; rq = r; mem_if.mem_ack = a;
    valid = 1'b0; data = 24'($urandom);
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      valid = 1'b1; data = rsp_q[0].data; void'(rsp_q.pop_front());
    end
    mem_if.mem_valid = valid; mem_if.mem_data = data;

    fire = mem_if.mem_req & a;
    chk("req_only_in_run", mem_if.mem_req & (m_state != S_RUN), 1'b0);
    if (prev_hold) begin
      chk("req_hold", mem_if.mem_req, 1'b1);
      chk("addr_hold", mem_if.mem_addr, prev_addr);
    end
    if (fire) begin
      chk("addr_seq", mem_if.mem_addr, m_addr);
      chk("credit", (q.size() + m_out) < D, 1'b1);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      e.due = d; e.data = 24'(mem_if.mem_addr);
      rsp_q.push_back(e);
    end
    rsp = valid && (m_out > 0);
    exp_uf = 1'b0;
    if (r) begin
      if (f || m_state != S_RUN) exp_color = UFC;
      else if (q.size() > 0) exp_color = q.pop_front();
      else begin
        exp_color = UFC; exp_uf = 1'b1;
        if (m_ucnt < 65535) m_ucnt++;
      end
    end
    if (m_state == S_RUN && rsp && !f) q.push_back(data);
    if (f) begin
      m_state = (m_out != 0 || fire) ? S_FLUSH : S_RUN;
      q.delete(); m_addr = 0;
    end else begin
      if (m_state == S_FLUSH && m_out == 0) m_state = S_RUN;
      if (fire) m_addr = (m_addr == PIX - 1) ? 0 : m_addr + 1;
    end
    m_out = m_out + int'(fire) - int'(rsp);
    prev_hold = mem_if.mem_req & ~a & ~f;
    prev_addr = mem_if.mem_addr;
    last_fire = fire;

    @(posedge clk); #1; cyc++;
    chk("color", color, exp_color);
    chk("underflow", uf, exp_uf);
    chk("underflow_cnt", ucnt, m_ucnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_color"}, color, 24'h000000);
    chk({tag, "_mem_req"}, mem_if.mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_if.mem_addr, 0);
    chk({tag, "_underflow"}, uf, 1'b0);
    chk({tag, "_underflow_cnt"}, ucnt, 16'h0000);
  endtask

  typedef struct {
    logic f, r, a;
    logic [23:0] color;
    logic ufl;
    logic req;
  } vec_t;

  vec_t vecs[9];
  int nf;
  logic [23:0] tp[32];

  initial begin
    mem_if.mem_ack = 1'b0; mem_if.mem_valid = 1'b0; mem_if.mem_data = 24'h000000;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef VGA_PIXEL_FEEDER_TESTPAT_EN
    fs = 1'b1; @(posedge clk); #1; fs = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("testpat_no_mem_req", mem_if.mem_req, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rq = 1'b1; @(posedge clk); #1; tp[i] = color;
    end
    rq = 1'b0;
    chk("testpat_px0", tp[0], 24'hFFFFFF);
    chk("testpat_px4", tp[4], 24'hFFFF00);
    chk("testpat_px8", tp[8], 24'h00FFFF);
    chk("testpat_px31", tp[31], 24'h000000);
    chk("testpat_no_underflow", ucnt, 16'h0000);
`else
    // Startup from IDLE with latency 2: {f, r, a, color, underflow, req after edge}
    vecs[0] = '{1'b0, 1'b1, 1'b1, UFC,          1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, UFC,          1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, UFC,          1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, UFC,          1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, UFC,          1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, UFC,          1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, UFC,          1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 24'h000000,   1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 24'h000001,   1'b0, 1'b1};
    lat = 2;
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].f, vecs[i].r, vecs[i].a);
      chk("vec_color", color, vecs[i].color);
      chk("vec_underflow", uf, vecs[i].ufl);
      chk("vec_mem_req", mem_if.mem_req, vecs[i].req);
    end

    // Steady streaming across a frame wrap: no further starvation
    repeat (25) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * PIX; i++) cycle(1'b0, 1'b1, 1'b1);
    chk("stream_underflow_cnt", ucnt, 16'd2);

    // Latency 40 from a clean frame start: 42 starved requests
    repeat (10) cycle(1'b0, 1'b0, 1'b1);
    lat = 40;
    cycle(1'b1, 1'b1, 1'b1);
    repeat (46) cycle(1'b0, 1'b1, 1'b1);
    chk("latency40_underflow_cnt", ucnt, 16'd44);

    // Frame start with 4 reads in flight: stale beats dropped, restart at 0
    repeat (80) cycle(1'b0, 1'b0, 1'b1);
    lat = 10;
    cycle(1'b1, 1'b0, 1'b0);
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, nf < 4);
      if (last_fire) nf++;
    end
    chk("flush_inflight", nf, 4);
    cycle(1'b1, 1'b0, 1'b0);
    chk("flush_req_low", mem_if.mem_req, 1'b0);
    repeat (30) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("flush_first_pixel", color, 24'h000000);
    chk("flush_no_underflow", ucnt, 16'd44);

    // Backpressure: ack held low while the display keeps consuming
    repeat (20) cycle(1'b0, 1'b1, 1'b0);
    chk("backpressure_req", mem_if.mem_req, 1'b1);
    repeat (20) cycle(1'b0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 6);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
    end

    // Asynchronous reset in the middle of a burst
    lat = 5;
    repeat (10) cycle(1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    fs = 1'b0; rq = 1'b0; mem_if.mem_ack = 1'b0; mem_if.mem_valid = 1'b0;
    q.delete(); m_state = S_IDLE; m_out = 0; m_addr = 0; m_ucnt = 0;
    exp_color = 24'h000000; prev_hold = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1; cyc++;
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    chk("post_reset_req", mem_if.mem_req, 1'b0);

    // Counter saturation with memory stalled
    cycle(1'b1, 1'b1, 1'b0);
    repeat (70000) cycle(1'b0, 1'b1, 1'b0);
    chk("saturation", ucnt, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
